// File: rtl/pixel_source_pkg.sv
// Shared constants and types for the pixel source: active-area geometry,
// pattern encodings, colour codes and box motion parameters.
package pixel_source_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BAR_W     = 80;
    localparam int BOX_SIZE  = 32;
    localparam int STEP      = 2;

    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int BAR_CNT_W = 7;

    localparam int H_LIMIT   = H_ACTIVE - BOX_SIZE;
    localparam int V_LIMIT   = V_ACTIVE - BOX_SIZE;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BLACK = 3'b000;
    localparam rgb_t RGB_WHITE = 3'b111;
    localparam rgb_t RGB_RED   = 3'b100;
    localparam rgb_t RGB_BLUE  = 3'b001;

endpackage

// File: rtl/pixel_source_box_mover.sv
// Bouncing-box position tracker: advances both axes by STEP once per frame
// and reverses direction when an axis would leave the visible range.
module pixel_source_box_mover
    import pixel_source_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           step,
    output logic [X_W-1:0] bx,
    output logic [Y_W-1:0] by
);

    dir_t dir_x;
    dir_t dir_y;

    // Position arithmetic is done in signed int so the lower clamp is a plain compare.
    function automatic int next_pos(input int pos, input dir_t dir, input int limit);
        if (dir == DIR_POS) begin
            return (pos + STEP > limit) ? limit : pos + STEP;
        end
        return (pos < STEP) ? 0 : pos - STEP;
    endfunction

    function automatic dir_t next_dir(input int pos, input dir_t dir, input int limit);
        if (dir == DIR_POS && pos + STEP > limit) begin
            return DIR_NEG;
        end
        if (dir == DIR_NEG && pos < STEP) begin
            return DIR_POS;
        end
        return dir;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx    <= '0;
            by    <= '0;
            dir_x <= DIR_POS;
            dir_y <= DIR_POS;
        end else if (step) begin
            bx    <= X_W'(next_pos(int'(bx), dir_x, H_LIMIT));
            by    <= Y_W'(next_pos(int'(by), dir_y, V_LIMIT));
            dir_x <= next_dir(int'(bx), dir_x, H_LIMIT);
            dir_y <= next_dir(int'(by), dir_y, V_LIMIT);
        end
    end

endmodule

// File: rtl/pixel_source.sv
// Test-pattern generator feeding the RGB stage: tracks the active pixel
// coordinate from hDisplay/vDisplay and drives registered 1-bit colours.
module pixel_source
    import pixel_source_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hDisplay,
    input  logic       vDisplay,
    input  logic [1:0] mode,
    output logic       rIn,
    output logic       gIn,
    output logic       bIn,
    output logic [9:0] px_x,
    output logic [8:0] px_y,
    output logic       frame_start
);

    localparam logic [X_W-1:0]       X_MAX    = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]       Y_MAX    = Y_W'(V_ACTIVE - 1);
    localparam logic [BAR_CNT_W-1:0] BAR_LAST = BAR_CNT_W'(BAR_W - 1);

    logic                 h_p1;
    logic                 v_p1;
    logic                 active_p0;
    logic                 h_fall_p0;
    logic                 v_fall_p0;
    logic [BAR_CNT_W-1:0] bar_sub;
    logic [2:0]           bar_idx;
    mode_t                mode_lat;
    logic                 armed;
    logic [X_W-1:0]       bx;
    logic [Y_W-1:0]       by;
    rgb_t                 colour_p0;

    function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
        return (v == X_MAX) ? v : v + X_W'(1);
    endfunction

    function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
        return (v == Y_MAX) ? v : v + Y_W'(1);
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        return {~idx[1], ~idx[2], ~idx[0]};
    endfunction

    function automatic logic in_box(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                    input logic [X_W-1:0] x0, input logic [Y_W-1:0] y0);
        return (int'(x) >= int'(x0)) && (int'(x) < int'(x0) + BOX_SIZE) &&
               (int'(y) >= int'(y0)) && (int'(y) < int'(y0) + BOX_SIZE);
    endfunction

    assign active_p0 = hDisplay & vDisplay;
    assign h_fall_p0 = h_p1 & ~hDisplay;
    assign v_fall_p0 = v_p1 & ~vDisplay;

    pixel_source_box_mover u_box (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (frame_start),
        .bx    (bx),
        .by    (by)
    );

    // Stage p0: pattern selection from the current coordinate.
    always_comb begin
        colour_p0 = RGB_BLACK;
        if (active_p0 && armed) begin
            case (mode_lat)
                MODE_WHITE: colour_p0 = RGB_WHITE;
                MODE_BARS:  colour_p0 = bar_colour(bar_idx);
                MODE_CHECK: colour_p0 = (px_x[5] ^ px_y[5]) ? RGB_BLACK : RGB_WHITE;
                MODE_BOX:   colour_p0 = in_box(px_x, px_y, bx, by) ? RGB_RED : RGB_BLUE;
                default:    colour_p0 = RGB_BLACK;
            endcase
        end
    end

    // Stage p1: registered colour, coordinates and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_p1            <= 1'b0;
            v_p1            <= 1'b0;
            px_x            <= '0;
            px_y            <= '0;
            bar_sub         <= '0;
            bar_idx         <= '0;
            frame_start     <= 1'b0;
            mode_lat        <= MODE_WHITE;
            armed           <= 1'b0;
            {rIn, gIn, bIn} <= RGB_BLACK;
        end else begin
            h_p1            <= hDisplay;
            v_p1            <= vDisplay;
            frame_start     <= v_fall_p0;
            {rIn, gIn, bIn} <= colour_p0;

            if (!hDisplay) begin
                px_x    <= '0;
                bar_sub <= '0;
                bar_idx <= '0;
            end else if (active_p0) begin
                px_x <= sat_inc_x(px_x);
                if (bar_sub == BAR_LAST) begin
                    bar_sub <= '0;
                    if (bar_idx != 3'd7) begin
                        bar_idx <= bar_idx + 3'd1;
                    end
                end else begin
                    bar_sub <= bar_sub + BAR_CNT_W'(1);
                end
            end

            // A vDisplay low always wins over a coincident hDisplay fall.
            if (!vDisplay) begin
                px_y <= '0;
            end else if (h_fall_p0) begin
                px_y <= sat_inc_y(px_y);
            end

            // Mode only takes effect at frame boundaries so a frame never mixes patterns.
            if (frame_start) begin
                mode_lat <= mode_t'(mode);
                armed    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_source.sv
// Scoreboard bench for pixel_source: randomized video timing, expected
// outputs queued per cycle from a reference model, compared by a monitor.
module tb_pixel_source;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hDisplay;
    logic       vDisplay;
    logic [1:0] mode;
    logic       rIn;
    logic       gIn;
    logic       bIn;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic       frame_start;

    pixel_source dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hDisplay    (hDisplay),
        .vDisplay    (vDisplay),
        .mode        (mode),
        .rIn         (rIn),
        .gIn         (gIn),
        .bIn         (bIn),
        .px_x        (px_x),
        .px_y        (px_y),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] rgb;
        int         x;
        int         y;
        bit         fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    // Reference model state: pixel count in line, line number, box, latched mode.
    int   cnt, ry, bx, by, dx, dy, lmode;
    bit   armed, pend, prev_h, prev_v;
    logic [2:0] bar_rgb [8];
    int   wide[$];
    int   sw_line = -1;
    int   sw_mode = 0;

    task automatic ref_reset();
        cnt = 0; ry = 0; bx = 0; by = 0; dx = 1; dy = 1; lmode = 0;
        armed = 0; pend = 0; prev_h = 0; prev_v = 0;
    endtask

    task automatic bounce(inout int p, inout int d, input int lim);
        if (d > 0) begin
            p = p + 2;
            if (p > lim) begin p = lim; d = -1; end
        end else begin
            p = p - 2;
            if (p < 0) begin p = 0; d = 1; end
        end
    endtask

    function automatic logic [2:0] ref_colour(input int m, input int c, input int y);
        int x;
        int bar;
        x   = (c > 639) ? 639 : c;
        bar = (c / 80 > 7) ? 7 : c / 80;
        case (m)
            0:       return 3'b111;
            1:       return bar_rgb[bar];
            2:       return (((x / 32) + (y / 32)) % 2 == 0) ? 3'b111 : 3'b000;
            default: return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 3'b100 : 3'b001;
        endcase
    endfunction

    // One pixel clock: drive inputs, let the DUT sample, queue what it must show.
    task automatic cyc(input bit h, input bit v, input bit rst = 1'b1);
        exp_t e;
        rst_n = rst; hDisplay = h; vDisplay = v;
        @(posedge clk);
        #1;
        if (!rst) begin
            ref_reset();
            e.rgb = 3'b000; e.x = 0; e.y = 0; e.fs = 1'b0;
        end else begin
            e.rgb = (h && v && armed) ? ref_colour(lmode, cnt, ry) : 3'b000;
            if (!h) cnt = 0;
            else if (v) cnt++;
            if (!v) ry = 0;
            else if (prev_h && !h && ry < 479) ry++;
            e.fs = prev_v && !v;
            if (pend) begin
                lmode = int'(mode);
                armed = 1'b1;
                bounce(bx, dx, 608);
                bounce(by, dy, 448);
            end
            pend   = e.fs;
            prev_h = h;
            prev_v = v;
            e.x = (cnt > 639) ? 639 : cnt;
            e.y = ry;
        end
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic vblank();
        cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
    endtask

    function automatic bit is_wide(input int l);
        foreach (wide[i]) if (wide[i] == l) return 1'b1;
        return 1'b0;
    endfunction

    task automatic frame(input int nlines, input int wmin, input int wmax, input bit together);
        for (int l = 0; l < nlines; l++) begin
            int w;
            if (l == sw_line) mode = 2'(sw_mode);
            w = is_wide(l) ? 645 : int'($urandom_range(wmax, wmin));
            repeat (w) cyc(1, 1);
            if (!(together && l == nlines - 1)) repeat ($urandom_range(3, 1)) cyc(0, 1);
        end
        vblank();
    endtask

    initial begin : monitor
        exp_t me;
        forever begin
            @(negedge clk);
            n_cyc++;
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                n_cmp++;
                if ({rIn, gIn, bIn} !== me.rgb || px_x !== me.x[9:0] || px_y !== me.y[8:0] ||
                    frame_start !== me.fs) begin
                    n_bad++;
                    $display("FAIL pixel cyc=%0d rgb=%b/%b px_x=%0d/%0d px_y=%0d/%0d fs=%b/%b (got/expected)",
                             n_cyc, {rIn, gIn, bIn}, me.rgb, px_x, me.x, px_y, me.y, frame_start, me.fs);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bar_rgb = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        rst_n = 1'b0; hDisplay = 1'b0; vDisplay = 1'b0; mode = 2'd0;
        ref_reset();

        repeat (4) cyc(0, 0, 0);
        repeat (3) cyc(0, 0);

        // Partial frame with a reset asserted mid-line: must stay black.
        repeat (3) cyc(0, 1);
        repeat (20) cyc(1, 1);
        repeat (2) cyc(0, 1);
        repeat (7) cyc(1, 1);
        repeat (3) cyc(1, 1, 0);
        repeat (30) cyc(1, 1);
        repeat (2) cyc(0, 1);
        repeat (15) cyc(1, 1);
        vblank();

        mode = 2'd1; frame(4, 1, 30, 1'b0);
        mode = 2'd2; wide = '{0, 1, 2}; frame(4, 1, 10, 1'b0);
        mode = 2'd0; wide = '{0, 33, 40}; frame(80, 1, 70, 1'b0);
        wide = '{}; sw_line = 100; sw_mode = 2;
        frame(490, 1, 8, 1'b1);
        sw_line = -1; mode = 2'd3; wide = '{0, 100, 199};
        frame(200, 1, 70, 1'b0);

        // Bouncing box: many short frames, periodically a tall frame around the box.
        for (int f = 0; f < 700; f++) begin
            if (f % 97 == 0) begin
                wide = '{by - 1, by, by + 31, by + 32};
                frame(by + 34, 1, 3, 1'(f % 2));
            end else begin
                wide = '{};
                frame(int'($urandom_range(2, 1)), 1, 4, 1'($urandom_range(1, 0)));
            end
        end

        // Reset in the middle of a frame, then one frame to re-arm and one shown.
        wide = '{};
        repeat (10) cyc(1, 1);
        repeat (2) cyc(1, 1, 0);
        repeat (10) cyc(1, 1);
        cyc(0, 1);
        repeat (5) cyc(1, 1);
        vblank();
        frame(3, 1, 20, 1'b0);
        wide = '{0};
        frame(40, 1, 40, 1'b1);

        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
